// File: rtl/final_project_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : final_project_pkg
//  Description : Shared definitions for the final_project_cpu slice.
//                It provides the data width, register count, default ROM
//                depth, instruction field positions, opcode encodings, an
//                instruction encoder and the default program image.
//  Revision    : 1.0 - initial release
// ============================================================================
package final_project_pkg;

    localparam int C_DATA_W        = 8;
    localparam int C_NUM_REGS      = 4;
    localparam int C_REG_IDX_W     = 2;
    localparam int C_ROM_DEPTH_DEF = 32;
    localparam int C_INSTR_W       = 16;

    // Instruction layout: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm8
    localparam int C_OPC_LSB = 12;
    localparam int C_OPC_W   = 4;
    localparam int C_RD_LSB  = 10;
    localparam int C_RS_LSB  = 8;
    localparam int C_IMM_LSB = 0;
    localparam int C_IMM_W   = 8;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_MOV  = 4'h2,
        OP_ADD  = 4'h3,
        OP_SUB  = 4'h4,
        OP_AND  = 4'h5,
        OP_OR   = 4'h6,
        OP_XOR  = 4'h7,
        OP_SHL  = 4'h8,
        OP_SHR  = 4'h9,
        OP_JMP  = 4'hA,
        OP_JZ   = 4'hB,
        OP_JNZ  = 4'hC,
        OP_DEC  = 4'hD,
        OP_NOP2 = 4'hE,
        OP_HALT = 4'hF
    } opcode_e;

    function automatic logic [C_INSTR_W-1:0] f_encode(
        input opcode_e              op,
        input logic [1:0]           rd,
        input logic [1:0]           rs,
        input logic [C_IMM_W-1:0]   imm
    );
        return {op, rd, rs, imm};
    endfunction

    // Default program: count R0 down from 5, adding R1 into R3 each pass.
    function automatic logic [C_INSTR_W-1:0] f_default_prog(input int idx);
        logic [C_INSTR_W-1:0] instr;
        instr = f_encode(OP_NOP, 2'd0, 2'd0, 8'h00);
        case (idx)
            0:       instr = f_encode(OP_LDI,  2'd0, 2'd0, 8'h05);
            1:       instr = f_encode(OP_LDI,  2'd1, 2'd0, 8'h03);
            2:       instr = f_encode(OP_MOV,  2'd2, 2'd0, 8'h00);
            3:       instr = f_encode(OP_ADD,  2'd2, 2'd1, 8'h00);
            4:       instr = f_encode(OP_LDI,  2'd3, 2'd0, 8'h00);
            5:       instr = f_encode(OP_ADD,  2'd3, 2'd1, 8'h00);
            6:       instr = f_encode(OP_DEC,  2'd0, 2'd0, 8'h00);
            7:       instr = f_encode(OP_JNZ,  2'd0, 2'd0, 8'h05);
            8:       instr = f_encode(OP_HALT, 2'd0, 2'd0, 8'h00);
            default: instr = f_encode(OP_NOP, 2'd0, 2'd0, 8'h00);
        endcase
        return instr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/final_project_alu.sv
`default_nettype none
// ============================================================================
//  Module      : final_project_alu
//  Description : Combinational datapath for final_project_cpu. Computes the
//                register write value and write-enable for one instruction.
//                Branch, NOP and HALT opcodes never write a register.
//  Ports       : opcode_i - instruction opcode
//                a_i      - R[rd] (pre-edge value)
//                b_i      - R[rs] (pre-edge value)
//                imm_i    - 8-bit immediate
//                result_o - value to write into R[rd]
//                we_o     - register write enable
//  Revision    : 1.0 - initial release
// ============================================================================
module final_project_alu
    import final_project_pkg::*;
(
    input  opcode_e              opcode_i,
    input  logic [C_DATA_W-1:0]  a_i,
    input  logic [C_DATA_W-1:0]  b_i,
    input  logic [C_IMM_W-1:0]   imm_i,
    output logic [C_DATA_W-1:0]  result_o,
    output logic                 we_o
);

    always_comb begin
        result_o = '0;
        we_o     = 1'b0;
        case (opcode_i)
            OP_LDI: begin result_o = imm_i;                         we_o = 1'b1; end
            OP_MOV: begin result_o = b_i;                           we_o = 1'b1; end
            OP_ADD: begin result_o = a_i + b_i;                     we_o = 1'b1; end
            OP_SUB: begin result_o = a_i - b_i;                     we_o = 1'b1; end
            OP_AND: begin result_o = a_i & b_i;                     we_o = 1'b1; end
            OP_OR:  begin result_o = a_i | b_i;                     we_o = 1'b1; end
            OP_XOR: begin result_o = a_i ^ b_i;                     we_o = 1'b1; end
            OP_SHL: begin result_o = {a_i[C_DATA_W-2:0], 1'b0};     we_o = 1'b1; end
            OP_SHR: begin result_o = {1'b0, a_i[C_DATA_W-1:1]};     we_o = 1'b1; end
            OP_DEC: begin result_o = a_i - {{(C_DATA_W-1){1'b0}}, 1'b1}; we_o = 1'b1; end
            default: begin
                result_o = '0;
                we_o     = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/final_project_cpu.sv
`default_nettype none
// ============================================================================
//  Module      : final_project_cpu
//  Description : 8-bit, four-register, single-cycle processor running a fixed
//                program from an internal ROM. Fetch, decode and execute are
//                combinational; the register file, PC and halt flag update on
//                the rising clock edge. R0..R3 are exported as reg1..reg4.
//  Config      : `FINAL_PROJECT_BRANCH_EN - when defined JZ/JNZ are
//                implemented; otherwise they execute as NOP.
//  Parameters  : ROM_DEPTH     - instruction ROM entries (PC wraps at end)
//                USE_ROM_IMAGE - 1: take program from ROM_IMAGE,
//                                0: use the built-in default program
//                ROM_IMAGE     - packed program, entry 0 in the low 16 bits
//  Ports       : clk   - system clock, rising edge
//                reset - asynchronous active-high reset
//                reg1..reg4 - R0..R3 contents
//  Revision    : 1.0 - initial release
// ============================================================================
module final_project_cpu
    import final_project_pkg::*;
#(
    parameter int                            ROM_DEPTH     = C_ROM_DEPTH_DEF,
    parameter bit                            USE_ROM_IMAGE = 1'b0,
    parameter logic [ROM_DEPTH*C_INSTR_W-1:0] ROM_IMAGE    = '0
)
(
    input  logic                 clk,
    input  logic                 reset,
    output logic [C_DATA_W-1:0]  reg1,
    output logic [C_DATA_W-1:0]  reg2,
    output logic [C_DATA_W-1:0]  reg3,
    output logic [C_DATA_W-1:0]  reg4
);

    localparam int PC_W = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PC_W-1:0]      pc_q;
    logic [PC_W-1:0]      pc_d;
    logic                 halt_q;
    logic                 halt_d;
    logic [C_DATA_W-1:0]  regs_q [C_NUM_REGS];

    // ------------------------------------------------------------------
    // Instruction ROM
    // ------------------------------------------------------------------
    logic [C_INSTR_W-1:0] w_rom [ROM_DEPTH];

    generate
        for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
            if (USE_ROM_IMAGE) begin : g_image
                assign w_rom[gi] = ROM_IMAGE[gi*C_INSTR_W +: C_INSTR_W];
            end else begin : g_default
                assign w_rom[gi] = f_default_prog(gi);
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Fetch / decode
    // ------------------------------------------------------------------
    logic [C_INSTR_W-1:0]   w_instr;
    opcode_e                w_opcode;
    logic [C_REG_IDX_W-1:0] w_rd;
    logic [C_REG_IDX_W-1:0] w_rs;
    logic [C_IMM_W-1:0]     w_imm;
    logic [C_DATA_W-1:0]    w_a;
    logic [C_DATA_W-1:0]    w_b;

    assign w_instr  = w_rom[pc_q];
    assign w_opcode = opcode_e'(w_instr[C_OPC_LSB +: C_OPC_W]);
    assign w_rd     = w_instr[C_RD_LSB +: C_REG_IDX_W];
    assign w_rs     = w_instr[C_RS_LSB +: C_REG_IDX_W];
    assign w_imm    = w_instr[C_IMM_LSB +: C_IMM_W];
    assign w_a      = regs_q[w_rd];
    assign w_b      = regs_q[w_rs];

    // ------------------------------------------------------------------
    // Execute
    // ------------------------------------------------------------------
    logic [C_DATA_W-1:0] w_result;
    logic                w_we;

    final_project_alu u_alu (
        .opcode_i (w_opcode),
        .a_i      (w_a),
        .b_i      (w_b),
        .imm_i    (w_imm),
        .result_o (w_result),
        .we_o     (w_we)
    );

    // ------------------------------------------------------------------
    // Branch and next-PC logic
    // ------------------------------------------------------------------
    logic            w_taken;
    logic [PC_W-1:0] w_target;
    logic [PC_W-1:0] w_pc_inc;

    assign w_target = w_imm[PC_W-1:0];
    assign w_pc_inc = (pc_q == PC_W'(ROM_DEPTH - 1)) ? '0 : pc_q + 1'b1;

    always_comb begin
        w_taken = 1'b0;
        case (w_opcode)
            OP_JMP: w_taken = 1'b1;
`ifdef FINAL_PROJECT_BRANCH_EN
            OP_JZ:  w_taken = (w_a == '0);
            OP_JNZ: w_taken = (w_a != '0);
`endif
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        halt_d = halt_q;
        pc_d   = pc_q;
        if (!halt_q) begin
            if (w_opcode == OP_HALT) begin
                // PC parks on the HALT instruction
                halt_d = 1'b1;
                pc_d   = pc_q;
            end else if (w_taken) begin
                pc_d = w_target;
            end else begin
                pc_d = w_pc_inc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q   <= '0;
            halt_q <= 1'b0;
            for (int i = 0; i < C_NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            pc_q   <= pc_d;
            halt_q <= halt_d;
            if (w_we && !halt_q) begin
                regs_q[w_rd] <= w_result;
            end
        end
    end

    assign reg1 = regs_q[0];
    assign reg2 = regs_q[1];
    assign reg3 = regs_q[2];
    assign reg4 = regs_q[3];

endmodule
`default_nettype wire

// File: tb/tb_final_project_cpu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_final_project_cpu
//  Description : Self-checking bench for final_project_cpu. Two instances run
//                side by side: the default program and a small override
//                program. An instruction-level interpreter predicts every
//                register after every edge; randomised asynchronous resets
//                are dropped into the middle of the default program.
//                Honours `FINAL_PROJECT_BRANCH_EN the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_final_project_cpu;

    typedef struct packed {
        logic [3:0][7:0] r;
        logic [4:0]      pc;
        logic            halt;
    } cpu_t;

`ifdef FINAL_PROJECT_BRANCH_EN
    localparam logic [7:0] EXP_R1 = 8'h00;
    localparam logic [7:0] EXP_R4 = 8'h0F;
    localparam bit         BR_EN  = 1'b1;
`else
    localparam logic [7:0] EXP_R1 = 8'h04;
    localparam logic [7:0] EXP_R4 = 8'h03;
    localparam bit         BR_EN  = 1'b0;
`endif
    localparam logic [7:0] EXP_R2 = 8'h03;
    localparam logic [7:0] EXP_R3 = 8'h08;

    // LDI R0,FF; LDI R1,02; ADD R0,R1; SHL R1; SUB R1,R0; HALT
    localparam logic [511:0] OVR_IMG = {{26{16'h0000}},
        16'hF000, 16'h4400, 16'h8400, 16'h3100, 16'h1402, 16'h10FF};

    logic       clk = 1'b0;
    logic       rst_main;
    logic       rst_ovr;
    logic [7:0] m1, m2, m3, m4;
    logic [7:0] o1, o2, o3, o4;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] rom_def [32];
    logic [15:0] rom_ovr [32];
    cpu_t        m_main;
    cpu_t        m_ovr;

    always #5 clk = ~clk;

    final_project_cpu dut (
        .clk   (clk),
        .reset (rst_main),
        .reg1  (m1),
        .reg2  (m2),
        .reg3  (m3),
        .reg4  (m4)
    );

    final_project_cpu #(
        .ROM_DEPTH     (32),
        .USE_ROM_IMAGE (1'b1),
        .ROM_IMAGE     (OVR_IMG)
    ) dut_ovr (
        .clk   (clk),
        .reset (rst_ovr),
        .reg1  (o1),
        .reg2  (o2),
        .reg3  (o3),
        .reg4  (o4)
    );

    function automatic logic [15:0] enc(input int op, input int rd, input int rs, input int imm);
        return {4'(op), 2'(rd), 2'(rs), 8'(imm)};
    endfunction

    // Instruction-set interpreter: one executed instruction per call.
    function automatic cpu_t step(input cpu_t s, input logic [15:0] ins);
        cpu_t       n;
        int         op;
        int         rd;
        int         rs;
        int         a;
        int         b;
        logic [7:0] imm;
        n = s;
        if (s.halt) return s;
        op  = int'(ins[15:12]);
        rd  = int'(ins[11:10]);
        rs  = int'(ins[9:8]);
        imm = ins[7:0];
        a   = int'(s.r[rd]);
        b   = int'(s.r[rs]);
        n.pc = 5'((int'(s.pc) + 1) % 32);
        case (op)
            1:  n.r[rd] = imm;
            2:  n.r[rd] = 8'(b);
            3:  n.r[rd] = 8'((a + b) % 256);
            4:  n.r[rd] = 8'((a - b + 256) % 256);
            5:  n.r[rd] = 8'(a & b);
            6:  n.r[rd] = 8'(a | b);
            7:  n.r[rd] = 8'(a ^ b);
            8:  n.r[rd] = 8'((a * 2) % 256);
            9:  n.r[rd] = 8'(a / 2);
            10: n.pc = imm[4:0];
            11: if (BR_EN && a == 0) n.pc = imm[4:0];
            12: if (BR_EN && a != 0) n.pc = imm[4:0];
            13: n.r[rd] = 8'((a + 255) % 256);
            15: begin n.halt = 1'b1; n.pc = s.pc; end
            default: ;
        endcase
        return n;
    endfunction

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 8'h%02h expected 8'h%02h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag, input cpu_t m,
                              input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
        cmp({tag, ".reg1"}, a, m.r[0]);
        cmp({tag, ".reg2"}, b, m.r[1]);
        cmp({tag, ".reg3"}, c, m.r[2]);
        cmp({tag, ".reg4"}, d, m.r[3]);
    endtask

    task automatic check_main_const(input string tag, input logic [7:0] e1,
                                    input logic [7:0] e2, input logic [7:0] e3,
                                    input logic [7:0] e4);
        cmp({tag, ".reg1"}, m1, e1);
        cmp({tag, ".reg2"}, m2, e2);
        cmp({tag, ".reg3"}, m3, e3);
        cmp({tag, ".reg4"}, m4, e4);
    endtask

    // One rising edge: advance the models, then check both DUTs mid-cycle.
    task automatic tick();
        @(posedge clk);
        if (!rst_main) m_main = step(m_main, rom_def[m_main.pc]);
        else           m_main = '0;
        if (!rst_ovr)  m_ovr  = step(m_ovr, rom_ovr[m_ovr.pc]);
        else           m_ovr  = '0;
        @(negedge clk);
        check_regs("main", m_main, m1, m2, m3, m4);
        check_regs("ovr",  m_ovr,  o1, o2, o3, o4);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rom_def[i] = 16'h0000;
            rom_ovr[i] = 16'h0000;
        end
        rom_def[0] = enc(1, 0, 0, 8'h05);
        rom_def[1] = enc(1, 1, 0, 8'h03);
        rom_def[2] = enc(2, 2, 0, 0);
        rom_def[3] = enc(3, 2, 1, 0);
        rom_def[4] = enc(1, 3, 0, 8'h00);
        rom_def[5] = enc(3, 3, 1, 0);
        rom_def[6] = enc(13, 0, 0, 0);
        rom_def[7] = enc(12, 0, 0, 5);
        rom_def[8] = enc(15, 0, 0, 0);
        rom_ovr[0] = enc(1, 0, 0, 8'hFF);
        rom_ovr[1] = enc(1, 1, 0, 8'h02);
        rom_ovr[2] = enc(3, 0, 1, 0);
        rom_ovr[3] = enc(8, 1, 0, 0);
        rom_ovr[4] = enc(4, 1, 0, 0);
        rom_ovr[5] = enc(15, 0, 0, 0);
        m_main = '0;
        m_ovr  = '0;

        // Reset held for two edges
        rst_main = 1'b1;
        rst_ovr  = 1'b1;
        #1;
        check_main_const("rst_initial", 8'h00, 8'h00, 8'h00, 8'h00);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_main_const("rst_held", 8'h00, 8'h00, 8'h00, 8'h00);
        cmp("ovr_rst_held.reg1", o1, 8'h00);
        #1;
        rst_main = 1'b0;
        rst_ovr  = 1'b0;

        // Default program to completion, override program alongside
        for (int e = 1; e <= 30; e++) begin
            tick();
            if (e == 2) begin
                cmp("edge2.reg1", m1, 8'h05);
                cmp("edge2.reg2", m2, 8'h03);
            end
            if (e == 4) cmp("edge4.reg3", m3, 8'h08);
            if (e == 6) begin
                cmp("edge6.reg4", m4, 8'h03);
                cmp("ovr_done.reg1", o1, 8'h01);
                cmp("ovr_done.reg2", o2, 8'h03);
            end
        end
        check_main_const("final", EXP_R1, EXP_R2, EXP_R3, EXP_R4);

        // Halted: outputs must hold
        for (int k = 0; k < 10; k++) begin
            tick();
            check_main_const("halted_hold", EXP_R1, EXP_R2, EXP_R3, EXP_R4);
        end
        cmp("ovr_final.reg1", o1, 8'h01);
        cmp("ovr_final.reg2", o2, 8'h03);

        // Randomised asynchronous resets part way through the program
        for (int round = 0; round < 3; round++) begin
            int unsigned k_edges;
            int unsigned off;
            rst_main = 1'b1;
            m_main   = '0;
            #2;
            rst_main = 1'b0;
            k_edges = $urandom_range(7, 18);
            off     = $urandom_range(1, 3);
            for (int e = 0; e < int'(k_edges); e++) tick();
            #(off);
            rst_main = 1'b1;
            m_main   = '0;
            #1;
            check_main_const("async_rst", 8'h00, 8'h00, 8'h00, 8'h00);
            tick();
            check_main_const("async_rst_held", 8'h00, 8'h00, 8'h00, 8'h00);
            #2;
            rst_main = 1'b0;
            for (int e = 0; e < 30; e++) tick();
            check_main_const("rerun_final", EXP_R1, EXP_R2, EXP_R3, EXP_R4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
